// File: rtl/ovi_pkg.sv
// ovi_pkg: shared OVI widths and store sink state encoding
package ovi_pkg;
   localparam int OVI_STORE_DATA_W = 512;
   localparam int OVI_SB_ID_W = 5;
   typedef enum logic [2:0] {SS_INIT, SS_IDLE, SS_ACTIVE, SS_DRAIN, SS_END} store_sink_state_e;
endpackage

// File: rtl/ovi_sync_fifo.sv
// ovi_sync_fifo: show-ahead synchronous FIFO with wrap-bit pointers
module ovi_sync_fifo #(
   parameter int W = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW:0] wp, rp;
   assign empty = wp == rp;
   assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign rdata = mem[rp[AW-1:0]];
   // pointers advance only on legal push/pop so callers cannot corrupt occupancy
   always_ff @(posedge clk)
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push && !full) wp <= wp + (AW+1)'(1);
         if (pop && !empty) rp <= rp + (AW+1)'(1);
      end
   // storage array needs no reset; empty flag masks stale contents
   always_ff @(posedge clk)
      if (push && !full) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/ovi_store_sink.sv
// ovi_store_sink: buffers OVI store beats under credit flow control and writes them to memory
module ovi_store_sink
   import ovi_pkg::*;
#(
   parameter int DATA_W = OVI_STORE_DATA_W,
   parameter int CREDITS = 4,
   parameter int ADDR_W = 64,
   parameter int BYTES_W = 16
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   START_VALID,
   input  logic [ADDR_W-1:0]      START_ADDR,
   input  logic [BYTES_W-1:0]     START_BYTES,
   input  logic [OVI_SB_ID_W-1:0] START_SB_ID,
   input  logic                   STORE_VALID,
   input  logic [DATA_W-1:0]      STORE_DATA,
   output logic                   STORE_CREDIT,
   output logic                   MEM_WR_VALID,
   output logic [ADDR_W-1:0]      MEM_WR_ADDR,
   output logic [DATA_W-1:0]      MEM_WR_DATA,
   output logic [DATA_W/8-1:0]    MEM_WR_STRB,
   input  logic                   MEM_WR_READY,
   output logic                   SYNC_END,
   output logic [OVI_SB_ID_W-1:0] SYNC_END_SB_ID,
   output logic                   BUSY,
   output logic                   PROTOCOL_ERR
);
   localparam int BPB = DATA_W/8;
   localparam int LB = $clog2(BPB);
   localparam int CW = $clog2(CREDITS);
   store_sink_state_e state, state_nx;
   logic [CW-1:0] init_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [OVI_SB_ID_W-1:0] sb_id_q;
   logic [BYTES_W-1:0] rx_left, wr_left, start_beats;
   logic [LB-1:0] rem_q;
   logic credit_q, err_q, push, pop, full, empty;
   logic [DATA_W-1:0] head;
   assign start_beats = (START_BYTES >> LB) + BYTES_W'(|START_BYTES[LB-1:0]);
   assign push = STORE_VALID && state == SS_ACTIVE && !full;
   assign pop = !empty && MEM_WR_READY;
   ovi_sync_fifo #(.W(DATA_W), .DEPTH(CREDITS)) u_fifo (
      .clk(CLK), .rst(RESET), .push(push), .wdata(STORE_DATA), .pop(pop),
      .rdata(head), .full(full), .empty(empty)
   );
   // state register
   always_ff @(posedge CLK)
      state <= RESET ? SS_INIT : state_nx;
   // next-state: credit grant, memop acceptance, receive, drain, completion
   always_comb begin
      state_nx = state;
      case (state)
         SS_INIT:   if (init_cnt == CW'(CREDITS-1)) state_nx = SS_IDLE;
         SS_IDLE:   if (START_VALID) state_nx = START_BYTES == '0 ? SS_END : SS_ACTIVE;
         SS_ACTIVE: if (push && rx_left == BYTES_W'(1)) state_nx = SS_DRAIN;
         SS_DRAIN:  if (empty && wr_left == '0) state_nx = SS_END;
         SS_END:    state_nx = SS_IDLE;
         default:   state_nx = SS_INIT;
      endcase
   end
   // memop bookkeeping, write address, pop credits and sticky error
   always_ff @(posedge CLK)
      if (RESET) begin
         init_cnt <= '0;
         addr_q <= '0;
         sb_id_q <= '0;
         rx_left <= '0;
         wr_left <= '0;
         rem_q <= '0;
         credit_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         init_cnt <= state == SS_INIT ? init_cnt + CW'(1) : '0;
         credit_q <= pop;
         err_q <= err_q || (STORE_VALID && (state != SS_ACTIVE || full)) || (START_VALID && state != SS_IDLE);
         if (state == SS_IDLE && START_VALID) begin
            addr_q <= START_ADDR;
            sb_id_q <= START_SB_ID;
            rx_left <= start_beats;
            wr_left <= start_beats;
            rem_q <= START_BYTES[LB-1:0];
         end else begin
            if (push) rx_left <= rx_left - BYTES_W'(1);
            if (pop) begin
               wr_left <= wr_left - BYTES_W'(1);
               addr_q <= addr_q + ADDR_W'(BPB);
            end
         end
      end
   // outputs; INIT credits are gated by RESET so none leak while reset is held
   always_comb begin
      BUSY = state != SS_IDLE;
      SYNC_END = state == SS_END;
      SYNC_END_SB_ID = SYNC_END ? sb_id_q : '0;
      STORE_CREDIT = credit_q || (state == SS_INIT && !RESET);
      PROTOCOL_ERR = err_q;
      MEM_WR_VALID = !empty;
      MEM_WR_ADDR = addr_q;
      MEM_WR_DATA = empty ? '0 : head;
      MEM_WR_STRB = empty ? '0 : (wr_left == BYTES_W'(1) && rem_q != '0) ? ~({BPB{1'b1}} << rem_q) : '1;
   end
endmodule

// File: tb/tb_ovi_store_sink.sv
// tb_ovi_store_sink: directed scenario bench for the OVI store sink
module tb_ovi_store_sink;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_valid = 1'b0;
   logic [63:0] start_addr = '0;
   logic [15:0] start_bytes = '0;
   logic [4:0] start_sb_id = '0;
   logic store_valid = 1'b0;
   logic [511:0] store_data = '0;
   logic store_credit, mem_wr_valid, sync_end, busy, protocol_err;
   logic [63:0] mem_wr_addr, mem_wr_strb;
   logic [511:0] mem_wr_data;
   logic mem_wr_ready = 1'b0;
   logic [4:0] sync_end_sb_id;
   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int last_pop_cyc = 0;
   logic [4:0] last_id = '0;
   logic [63:0] wa[$];
   logic [511:0] wd[$];
   logic [63:0] ws[$];
   int cq[$];
   int sq[$];

   ovi_store_sink dut (
      .CLK(clk), .RESET(rst), .START_VALID(start_valid), .START_ADDR(start_addr),
      .START_BYTES(start_bytes), .START_SB_ID(start_sb_id), .STORE_VALID(store_valid),
      .STORE_DATA(store_data), .STORE_CREDIT(store_credit), .MEM_WR_VALID(mem_wr_valid),
      .MEM_WR_ADDR(mem_wr_addr), .MEM_WR_DATA(mem_wr_data), .MEM_WR_STRB(mem_wr_strb),
      .MEM_WR_READY(mem_wr_ready), .SYNC_END(sync_end), .SYNC_END_SB_ID(sync_end_sb_id),
      .BUSY(busy), .PROTOCOL_ERR(protocol_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // record accepted writes, credit pulses and completions away from the active edge
   always @(negedge clk) begin
      if (mem_wr_valid && mem_wr_ready) begin
         wa.push_back(mem_wr_addr);
         wd.push_back(mem_wr_data);
         ws.push_back(mem_wr_strb);
         last_pop_cyc = cyc;
      end
      if (store_credit) cq.push_back(cyc);
      if (sync_end) begin
         sq.push_back(cyc);
         last_id = sync_end_sb_id;
      end
   end

   function automatic logic [511:0] beat(input int i);
      return {16{32'hA500_0000 + 32'(i)}};
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [63:0] a, input logic [15:0] b, input logic [4:0] id);
      start_valid = 1'b1;
      start_addr = a;
      start_bytes = b;
      start_sb_id = id;
      idle(1);
      start_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [511:0] d);
      store_valid = 1'b1;
      store_data = d;
      idle(1);
      store_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (store_credit !== 1'b0) begin n_err++; $display("FAIL rst_credit got %b want 0", store_credit); end
      n_cmp++; if (mem_wr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", mem_wr_valid); end
      n_cmp++; if (mem_wr_addr !== 64'h0) begin n_err++; $display("FAIL rst_addr got %h want 0", mem_wr_addr); end
      n_cmp++; if (mem_wr_data !== 512'h0) begin n_err++; $display("FAIL rst_data got %h want 0", mem_wr_data[31:0]); end
      n_cmp++; if (mem_wr_strb !== 64'h0) begin n_err++; $display("FAIL rst_strb got %h want 0", mem_wr_strb); end
      n_cmp++; if (sync_end !== 1'b0 || sync_end_sb_id !== 5'd0) begin n_err++; $display("FAIL rst_sync got %b/%0d want 0/0", sync_end, sync_end_sb_id); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_busy got %b want 1", busy); end
      n_cmp++; if (protocol_err !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", protocol_err); end
      @(posedge clk);
      #1 rst = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         n_cmp++; if (store_credit !== (c <= 4)) begin n_err++; $display("FAIL init_credit cycle %0d got %b want %b", c, store_credit, c <= 4); end
         n_cmp++; if (busy !== (c <= 4)) begin n_err++; $display("FAIL init_busy cycle %0d got %b want %b", c, busy, c <= 4); end
      end
      idle(1);
   endtask

   task automatic test_two_beats;
      int wb = wa.size();
      int cb = cq.size();
      int sb = sq.size();
      mem_wr_ready = 1'b1;
      start_op(64'h1000, 16'd128, 5'd3);
      send_beat(beat(1));
      send_beat(beat(2));
      idle(6);
      n_cmp++; if (wa.size() - wb !== 2) begin n_err++; $display("FAIL two_nwr got %0d want 2", wa.size() - wb); end
      else begin
         n_cmp++; if (wa[wb] !== 64'h1000 || wa[wb+1] !== 64'h1040) begin n_err++; $display("FAIL two_addr got %h/%h want 1000/1040", wa[wb], wa[wb+1]); end
         n_cmp++; if (ws[wb] !== '1 || ws[wb+1] !== '1) begin n_err++; $display("FAIL two_strb got %h/%h want all ones", ws[wb], ws[wb+1]); end
         n_cmp++; if (wd[wb] !== beat(1) || wd[wb+1] !== beat(2)) begin n_err++; $display("FAIL two_data got %h/%h want %h/%h", wd[wb][31:0], wd[wb+1][31:0], beat(1)[31:0], beat(2)[31:0]); end
      end
      n_cmp++; if (cq.size() - cb !== 2) begin n_err++; $display("FAIL two_credits got %0d want 2", cq.size() - cb); end
      n_cmp++; if (sq.size() - sb !== 1 || last_id !== 5'd3) begin n_err++; $display("FAIL two_sync got %0d/id %0d want 1/id 3", sq.size() - sb, last_id); end
      n_cmp++; if (sq.size() == 0 || sq[$] !== last_pop_cyc + 2) begin n_err++; $display("FAIL two_sync_lat got %0d want %0d", sq.size() ? sq[$] : -1, last_pop_cyc + 2); end
      n_cmp++; if (busy !== 1'b0 || protocol_err !== 1'b0) begin n_err++; $display("FAIL two_idle busy %b err %b want 0 0", busy, protocol_err); end
   endtask

   task automatic test_partial;
      int wb = wa.size();
      int sb = sq.size();
      mem_wr_ready = 1'b1;
      start_op(64'h2000, 16'd100, 5'd5);
      send_beat(beat(3));
      send_beat(beat(4));
      idle(6);
      n_cmp++; if (wa.size() - wb !== 2) begin n_err++; $display("FAIL part_nwr got %0d want 2", wa.size() - wb); end
      else begin
         n_cmp++; if (ws[wb] !== '1) begin n_err++; $display("FAIL part_strb0 got %h want all ones", ws[wb]); end
         n_cmp++; if (ws[wb+1] !== 64'h0000_000F_FFFF_FFFF) begin n_err++; $display("FAIL part_strb1 got %h want 0000000fffffffff", ws[wb+1]); end
         n_cmp++; if (wa[wb+1] !== 64'h2040) begin n_err++; $display("FAIL part_addr got %h want 2040", wa[wb+1]); end
      end
      n_cmp++; if (sq.size() - sb !== 1 || last_id !== 5'd5) begin n_err++; $display("FAIL part_sync got %0d/id %0d want 1/id 5", sq.size() - sb, last_id); end
   endtask

   task automatic test_zero;
      int wb = wa.size();
      int cb = cq.size();
      int sb = sq.size();
      mem_wr_ready = 1'b1;
      start_op(64'h7000, 16'd0, 5'd7);
      n_cmp++; if (sync_end !== 1'b1 || sync_end_sb_id !== 5'd7) begin n_err++; $display("FAIL zero_sync got %b/%0d want 1/7", sync_end, sync_end_sb_id); end
      idle(3);
      n_cmp++; if (sq.size() - sb !== 1) begin n_err++; $display("FAIL zero_nsync got %0d want 1", sq.size() - sb); end
      n_cmp++; if (wa.size() - wb !== 0 || cq.size() - cb !== 0) begin n_err++; $display("FAIL zero_traffic got %0d writes %0d credits want 0 0", wa.size() - wb, cq.size() - cb); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy got %b want 0", busy); end
   endtask

   task automatic test_backpressure;
      int wb = wa.size();
      int cb = cq.size();
      int sb = sq.size();
      mem_wr_ready = 1'b0;
      start_op(64'h3000, 16'd256, 5'd9);
      store_valid = 1'b1;
      store_data = beat(10);
      @(negedge clk);
      n_cmp++; if (mem_wr_valid !== 1'b0) begin n_err++; $display("FAIL bp_comb_path got %b want 0", mem_wr_valid); end
      idle(1);
      store_valid = 1'b0;
      n_cmp++; if (mem_wr_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_lat got %b want 1", mem_wr_valid); end
      for (int i = 11; i <= 13; i++) send_beat(beat(i));
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n_cmp++; if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 64'h3000 || mem_wr_data !== beat(10) || mem_wr_strb !== '1) begin n_err++; $display("FAIL bp_stable cycle %0d got v%b a%h d%h want v1 a3000 d%h", k, mem_wr_valid, mem_wr_addr, mem_wr_data[31:0], beat(10)[31:0]); end
      end
      n_cmp++; if (cq.size() - cb !== 0) begin n_err++; $display("FAIL bp_no_credit got %0d want 0", cq.size() - cb); end
      @(posedge clk);
      #1 mem_wr_ready = 1'b1;
      idle(8);
      n_cmp++; if (cq.size() - cb !== 4) begin n_err++; $display("FAIL bp_credits got %0d want 4", cq.size() - cb); end
      else begin
         n_cmp++; if (cq[cb+3] - cq[cb] !== 3) begin n_err++; $display("FAIL bp_credit_spacing got %0d want 3", cq[cb+3] - cq[cb]); end
      end
      n_cmp++; if (wa.size() - wb !== 4) begin n_err++; $display("FAIL bp_nwr got %0d want 4", wa.size() - wb); end
      else begin
         n_cmp++; if (wa[wb+3] !== 64'h30C0 || wd[wb+3] !== beat(13)) begin n_err++; $display("FAIL bp_last_wr got %h/%h want 30c0/%h", wa[wb+3], wd[wb+3][31:0], beat(13)[31:0]); end
      end
      n_cmp++; if (sq.size() - sb !== 1 || last_id !== 5'd9) begin n_err++; $display("FAIL bp_sync got %0d/id %0d want 1/id 9", sq.size() - sb, last_id); end
   endtask

   task automatic test_errors;
      int wb, sb;
      mem_wr_ready = 1'b0;
      send_beat(beat(99));
      n_cmp++; if (protocol_err !== 1'b1 || mem_wr_valid !== 1'b0) begin n_err++; $display("FAIL err_idle_beat got err %b valid %b want 1 0", protocol_err, mem_wr_valid); end
      wb = wa.size();
      sb = sq.size();
      start_op(64'h4000, 16'd320, 5'd12);
      for (int i = 20; i <= 24; i++) send_beat(beat(i));
      n_cmp++; if (mem_wr_data !== beat(20)) begin n_err++; $display("FAIL err_head got %h want %h", mem_wr_data[31:0], beat(20)[31:0]); end
      mem_wr_ready = 1'b1;
      idle(5);
      n_cmp++; if (mem_wr_valid !== 1'b0 || busy !== 1'b1 || sq.size() !== sb) begin n_err++; $display("FAIL err_wait got valid %b busy %b syncs %0d want 0 1 0", mem_wr_valid, busy, sq.size() - sb); end
      send_beat(beat(25));
      idle(6);
      n_cmp++; if (wa.size() - wb !== 5) begin n_err++; $display("FAIL err_nwr got %0d want 5", wa.size() - wb); end
      else begin
         n_cmp++; if (wd[wb+3] !== beat(23) || wd[wb+4] !== beat(25) || wa[wb+4] !== 64'h4100) begin n_err++; $display("FAIL err_data got %h/%h @%h want %h/%h @4100", wd[wb+3][31:0], wd[wb+4][31:0], wa[wb+4], beat(23)[31:0], beat(25)[31:0]); end
      end
      n_cmp++; if (sq.size() - sb !== 1 || last_id !== 5'd12 || protocol_err !== 1'b1) begin n_err++; $display("FAIL err_end got %0d/id %0d err %b want 1/id 12 err 1", sq.size() - sb, last_id, protocol_err); end
   endtask

   task automatic test_reset_mid;
      int wb, cb, sb;
      mem_wr_ready = 1'b0;
      start_op(64'h5000, 16'd128, 5'd4);
      send_beat(beat(30));
      n_cmp++; if (mem_wr_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre got %b want 1", mem_wr_valid); end
      rst = 1'b1;
      idle(1);
      n_cmp++; if (mem_wr_valid !== 1'b0 || busy !== 1'b1 || protocol_err !== 1'b0 || store_credit !== 1'b0) begin n_err++; $display("FAIL mid_rst got v%b b%b e%b c%b want 0 1 0 0", mem_wr_valid, busy, protocol_err, store_credit); end
      wb = wa.size();
      cb = cq.size();
      sb = sq.size();
      rst = 1'b0;
      start_op(64'h6000, 16'd64, 5'd2);
      idle(8);
      n_cmp++; if (cq.size() - cb !== 4) begin n_err++; $display("FAIL mid_credits got %0d want 4", cq.size() - cb); end
      n_cmp++; if (wa.size() !== wb || sq.size() !== sb) begin n_err++; $display("FAIL mid_traffic got %0d writes %0d syncs want 0 0", wa.size() - wb, sq.size() - sb); end
      n_cmp++; if (protocol_err !== 1'b1 || busy !== 1'b0 || mem_wr_addr !== 64'h0) begin n_err++; $display("FAIL mid_start_ignored got err %b busy %b addr %h want 1 0 0", protocol_err, busy, mem_wr_addr); end
   endtask

   initial begin
      test_reset;
      test_two_beats;
      test_partial;
      test_zero;
      test_backpressure;
      test_errors;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
